// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: funct codes, FSM states,
// datapath mode and the default operand width.
package muldiv_ctrl_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_e;

    function automatic logic is_muldiv_funct(input logic [5:0] f);
        return (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO) ||
               (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned multiply (shift-add, right shifting) or
// restoring divide (shift-subtract, left shifting) on a 2W-bit accumulator.
module muldiv_step
    import muldiv_ctrl_pkg::*;
#(
    parameter int W = DEF_WIDTH
) (
    input  mode_e            mode_i,
    input  logic [2*W-1:0]   acc_i,
    input  logic [W-1:0]     op_i,
    output logic [2*W-1:0]   acc_o
);

    logic [W:0] sum;
    logic [W:0] rem_sh;
    logic [W:0] diff;
    logic       ge;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}.
        sum    = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, op_i} : '0);
        // Divide: acc = {partial remainder, remaining dividend bits}.
        rem_sh = acc_i[2*W-1:W-1];
        diff   = rem_sh - {1'b0, op_i};
        ge     = (rem_sh >= {1'b0, op_i});
        if (mode_i == MODE_DIV) begin
            acc_o = {(ge ? diff[W-1:0] : rem_sh[W-1:0]), acc_i[W-2:0], ge};
        end else begin
            acc_o = {sum, acc_i[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative mult/multu/div/divu sequencer owning HI/LO; also services
// mthi/mtlo/mfhi/mflo and stalls muldiv-group instructions while busy.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             Muldiv_req,
    input  logic [5:0]       Function_opcode,
    input  logic [WIDTH-1:0] Read_data_1,
    input  logic [WIDTH-1:0] Read_data_2,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic             Div_zero,
    output logic [WIDTH-1:0] Mf_Result,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   op_q, op_d;
    mode_e              mode_q, mode_d;
    logic               neg_q, neg_d, neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d, done_q, done_d;

    logic               signed_op, rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_abs, rt_abs;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_quot, fix_rem;
    logic               fix_dz;

    muldiv_step #(.W(WIDTH)) u_step (
        .mode_i (mode_q),
        .acc_i  (acc_q),
        .op_i   (op_q),
        .acc_o  (acc_step)
    );

    // funct[0] selects the unsigned variant, funct[1] selects divide.
    assign signed_op = ~Function_opcode[0];
    assign rs_neg    = signed_op & Read_data_1[WIDTH-1];
    assign rt_neg    = signed_op & Read_data_2[WIDTH-1];
    assign rs_abs    = rs_neg ? -Read_data_1 : Read_data_1;
    assign rt_abs    = rt_neg ? -Read_data_2 : Read_data_2;

    // Divide by zero leaves |rs| as remainder; restoring rs's sign yields rs itself.
    assign fix_prod  = neg_q ? -acc_q : acc_q;
    assign fix_dz    = (mode_q == MODE_DIV) && (op_q == '0);
    assign fix_quot  = fix_dz ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign fix_rem   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        acc_d      = acc_q;
        op_d       = op_q;
        mode_d     = mode_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (Muldiv_req) begin
                    case (Function_opcode)
                        F_MTHI: hi_d = Read_data_1;
                        F_MTLO: lo_d = Read_data_1;
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            if (Function_opcode[1]) begin
                                mode_d = MODE_DIV;
                                acc_d  = {{WIDTH{1'b0}}, rs_abs};
                                op_d   = rt_abs;
                            end else begin
                                mode_d = MODE_MUL;
                                acc_d  = {{WIDTH{1'b0}}, rt_abs};
                                op_d   = rs_abs;
                            end
                            neg_d      = rs_neg ^ rt_neg;
                            neg_rem_d  = rs_neg;
                            cnt_d      = '0;
                            div_zero_d = 1'b0;
                            state_d    = CALC;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (mode_q == MODE_DIV) begin
                    hi_d       = fix_rem;
                    lo_d       = fix_quot;
                    div_zero_d = fix_dz;
                end else begin
                    {hi_d, lo_d} = fix_prod;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            acc_q      <= '0;
            op_q       <= '0;
            mode_q     <= MODE_MUL;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            acc_q      <= acc_d;
            op_q       <= op_d;
            mode_q     <= mode_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign Busy        = (state_q != IDLE);
    assign Stall       = Muldiv_req & Busy & is_muldiv_funct(Function_opcode);
    assign Done        = done_q;
    assign Div_zero    = div_zero_q;
    assign dbg_state_o = state_q;
    assign Mf_Result   = (Function_opcode == F_MFHI) ? hi_q :
                         (Function_opcode == F_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;

    localparam logic [5:0] T_MFHI  = 6'b010000;
    localparam logic [5:0] T_MTHI  = 6'b010001;
    localparam logic [5:0] T_MFLO  = 6'b010010;
    localparam logic [5:0] T_MTLO  = 6'b010011;
    localparam logic [5:0] T_MULT  = 6'b011000;
    localparam logic [5:0] T_MULTU = 6'b011001;
    localparam logic [5:0] T_DIV   = 6'b011010;
    localparam logic [5:0] T_DIVU  = 6'b011011;
    localparam logic [5:0] T_ADD   = 6'b100000;
    localparam int LAT = 33;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [5:0]  funct = T_ADD;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        stall, busy, done, div_zero;
    logic [31:0] mf_result;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    muldiv_ctrl dut (
        .clock           (clock),
        .rst_n           (rst_n),
        .Muldiv_req      (req),
        .Function_opcode (funct),
        .Read_data_1     (rs),
        .Read_data_2     (rt),
        .Stall           (stall),
        .Busy            (busy),
        .Done            (done),
        .Div_zero        (div_zero),
        .Mf_Result       (mf_result),
        .dbg_state_o     (dbg_state)
    );

    always #5 clock = ~clock;

    // Reference: MIPS HI/LO semantics from plain integer arithmetic.
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint      pa, pb, ps;
        logic [63:0] pu;
        int          sa, sb;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (f)
            T_MULT: begin
                pa = longint'($signed(a));
                pb = longint'($signed(b));
                ps = pa * pb;
                {hi, lo} = ps;
            end
            T_MULTU: begin
                pu = {32'b0, a} * {32'b0, b};
                {hi, lo} = pu;
            end
            T_DIV, T_DIVU: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                    dz = 1'b1;
                end else if (f == T_DIVU) begin
                    lo = a / b;
                    hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'd0;
                end else begin
                    sa = a;
                    sb = b;
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
            default: ;
        endcase
    endfunction

    // Called at a negedge; counts negedges seen with Busy high, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic run_arith(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ehi, elo;
        logic        edz;
        int          n;
        model(f, a, b, ehi, elo, edz);
        @(negedge clock);
        req = 1'b1; funct = f; rs = a; rt = b;
        @(negedge clock);
        req = 1'b0; funct = T_ADD;
        wait_idle(n);
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL latency f=%b a=%h b=%h busy_cycles=%0d want=%0d", f, a, b, n, LAT);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse f=%b a=%h b=%h got=%b want=1", f, a, b, done);
        end
        funct = T_MFHI; #1;
        checks++;
        if (mf_result !== ehi) begin
            errors++;
            $display("FAIL hi f=%b a=%h b=%h got=%h want=%h", f, a, b, mf_result, ehi);
        end
        funct = T_MFLO; #1;
        checks++;
        if (mf_result !== elo) begin
            errors++;
            $display("FAIL lo f=%b a=%h b=%h got=%h want=%h", f, a, b, mf_result, elo);
        end
        checks++;
        if (div_zero !== edz) begin
            errors++;
            $display("FAIL div_zero f=%b a=%h b=%h got=%b want=%b", f, a, b, div_zero, edz);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width f=%b got=%b want=0", f, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_flags busy=%b stall=%b done=%b dz=%b st=%0d want all 0",
                     busy, stall, done, div_zero, dbg_state);
        end
        funct = T_MFHI; #1;
        checks++;
        if (mf_result !== 32'd0) begin
            errors++;
            $display("FAIL reset_hi got=%h want=0", mf_result);
        end
        funct = T_MFLO; #1;
        checks++;
        if (mf_result !== 32'd0) begin
            errors++;
            $display("FAIL reset_lo got=%h want=0", mf_result);
        end
        @(negedge clock);
        rst_n = 1'b1;
        funct = T_ADD;
    endtask

    task automatic test_directed();
        run_arith(T_MULT,  32'hFFFF_FFFE, 32'd3);
        run_arith(T_MULTU, 32'hFFFF_FFFE, 32'd3);
        run_arith(T_DIV,   32'hFFFF_FFF9, 32'd2);
        run_arith(T_DIVU,  32'd7,         32'd2);
        run_arith(T_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_arith(T_DIV,   32'd7,         32'hFFFF_FFFE);
    endtask

    task automatic test_div_zero();
        run_arith(T_DIVU, 32'h0000_1234, 32'd0);
        run_arith(T_MULT, 32'd5, 32'd6);
        run_arith(T_DIV,  32'hFFFF_FF00, 32'd0);
        run_arith(T_DIVU, 32'd100, 32'd9);
    endtask

    task automatic test_mult_mflo_stall();
        logic [31:0] a, b, ehi, elo;
        logic        edz;
        int          n, dn;
        a = $urandom; b = $urandom;
        model(T_MULT, a, b, ehi, elo, edz);
        @(negedge clock);
        req = 1'b1; funct = T_MULT; rs = a; rt = b;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL issue_no_stall got=%b want=0", stall);
        end
        @(negedge clock);
        funct = T_MFLO;
        #1;
        n = 0; dn = 0;
        while (stall === 1'b1 && n < 200) begin
            n++;
            if (done === 1'b1) dn++;
            @(negedge clock);
            #1;
        end
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL mflo_stall_cycles got=%0d want=%0d", n, LAT);
        end
        checks++;
        if (mf_result !== elo) begin
            errors++;
            $display("FAIL mflo_after_stall got=%h want=%h", mf_result, elo);
        end
        if (done === 1'b1) dn++;
        @(negedge clock);
        req = 1'b0; funct = T_ADD;
        repeat (3) begin
            #1;
            if (done === 1'b1) dn++;
            @(negedge clock);
        end
        checks++;
        if (dn !== 1) begin
            errors++;
            $display("FAIL done_count got=%0d want=1", dn);
        end
    endtask

    task automatic test_mthi_mfhi();
        @(negedge clock);
        req = 1'b1; funct = T_MTHI; rs = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL mthi_stall got=%b want=0", stall);
        end
        @(negedge clock);
        funct = T_MFHI; rs = 32'd0;
        #1;
        checks++;
        if (stall !== 1'b0 || mf_result !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mfhi_idle stall=%b got=%h want=deadbeef", stall, mf_result);
        end
        @(negedge clock);
        funct = T_MTLO; rs = 32'h0BAD_F00D;
        @(negedge clock);
        funct = T_MFLO;
        #1;
        checks++;
        if (stall !== 1'b0 || mf_result !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL mflo_idle stall=%b got=%h want=0badf00d", stall, mf_result);
        end
        funct = T_MFHI; #1;
        checks++;
        if (mf_result !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mtlo_kept_hi got=%h want=deadbeef", mf_result);
        end
        @(negedge clock);
        req = 1'b0; funct = T_ADD;
    endtask

    task automatic test_mtlo_busy();
        logic [31:0] a, b, v, ehi, elo;
        logic        edz;
        int          n;
        a = $urandom; b = $urandom; v = $urandom;
        model(T_MULTU, a, b, ehi, elo, edz);
        @(negedge clock);
        req = 1'b1; funct = T_MULTU; rs = a; rt = b;
        @(negedge clock);
        funct = T_MTLO; rs = v;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 200) begin
            n++;
            @(negedge clock);
            #1;
        end
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL mtlo_stall_cycles got=%0d want=%0d", n, LAT);
        end
        @(negedge clock);
        req = 1'b0; funct = T_MFLO;
        #1;
        checks++;
        if (mf_result !== v) begin
            errors++;
            $display("FAIL mtlo_after_busy got=%h want=%h", mf_result, v);
        end
        funct = T_MFHI; #1;
        checks++;
        if (mf_result !== ehi) begin
            errors++;
            $display("FAIL mtlo_busy_hi got=%h want=%h", mf_result, ehi);
        end
        funct = T_ADD;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c, d, h1, l1, h2, l2;
        logic        z1, z2;
        int          n;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom_range(1, 1000);
        model(T_MULT, a, b, h1, l1, z1);
        model(T_DIV, c, d, h2, l2, z2);
        @(negedge clock);
        req = 1'b1; funct = T_MULT; rs = a; rt = b;
        @(negedge clock);
        req = 1'b0; funct = T_ADD;
        wait_idle(n);
        req = 1'b1; funct = T_DIV; rs = c; rt = d;
        @(negedge clock);
        req = 1'b0; funct = T_MFHI;
        #1;
        checks++;
        if (busy !== 1'b1 || mf_result !== h1) begin
            errors++;
            $display("FAIL b2b_accept busy=%b hi=%h want busy=1 hi=%h", busy, mf_result, h1);
        end
        funct = T_MFLO; #1;
        checks++;
        if (mf_result !== l1) begin
            errors++;
            $display("FAIL b2b_first_lo got=%h want=%h", mf_result, l1);
        end
        funct = T_ADD;
        wait_idle(n);
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL b2b_latency got=%0d want=%0d", n, LAT);
        end
        funct = T_MFLO; #1;
        checks++;
        if (mf_result !== l2) begin
            errors++;
            $display("FAIL b2b_second_lo got=%h want=%h", mf_result, l2);
        end
        funct = T_MFHI; #1;
        checks++;
        if (mf_result !== h2) begin
            errors++;
            $display("FAIL b2b_second_hi got=%h want=%h", mf_result, h2);
        end
        funct = T_ADD;
    endtask

    task automatic test_random();
        logic [5:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: f = T_MULT;
                1: f = T_MULTU;
                2: f = T_DIV;
                default: f = T_DIVU;
            endcase
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
                3: b = -$urandom_range(1, 20);
                default: ;
            endcase
            run_arith(f, a, b);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        req = 1'b1; funct = T_MTHI; rs = 32'h1111_2222;
        @(negedge clock);
        funct = T_MTLO; rs = 32'h3333_4444;
        @(negedge clock);
        funct = T_MULT; rs = $urandom; rt = $urandom;
        @(negedge clock);
        req = 1'b0; funct = T_ADD;
        repeat (10) @(negedge clock);
        checks++;
        if (dbg_state !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_calc state=%0d busy=%b want state=1 busy=1", dbg_state, busy);
        end
        req = 1'b1; funct = T_MFLO;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL abort_flags busy=%b stall=%b done=%b st=%0d want all 0",
                     busy, stall, done, dbg_state);
        end
        checks++;
        if (mf_result !== 32'd0) begin
            errors++;
            $display("FAIL abort_lo got=%h want=0", mf_result);
        end
        funct = T_MFHI; #1;
        checks++;
        if (mf_result !== 32'd0) begin
            errors++;
            $display("FAIL abort_hi got=%h want=0", mf_result);
        end
        @(negedge clock);
        rst_n = 1'b1;
        funct = T_MFLO;
        @(negedge clock);
        #1;
        checks++;
        if (mf_result !== 32'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL mflo_after_reset got=%h stall=%b want 0/0", mf_result, stall);
        end
        req = 1'b0; funct = T_ADD;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_mult_mflo_stall();
        test_mthi_mfhi();
        test_mtlo_busy();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
